// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control path.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/aluDeco.sv
// ALU decoder: maps aluOp plus funct fields onto an ALU operation code.
module aluDeco
  import ctrl_pkg::*;
(
  input  logic       op5,
  input  logic       f7,
  input  logic [2:0] f3,
  input  logic [1:0] aluOp,
  output logic [2:0] ALUcontrol
);

  // Fixed add/sub for address and compare work, funct decode otherwise.
  always_comb begin
    ALUcontrol = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: ALUcontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (f3)
          3'b000:  ALUcontrol = (op5 & f7) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUcontrol = ALU_SLT;
          3'b110:  ALUcontrol = ALU_OR;
          3'b111:  ALUcontrol = ALU_AND;
          default: ALUcontrol = ALU_ADD;
        endcase
      end
      default: ALUcontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences the shared datapath and memory port.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       f3,
  input  logic             f7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             memWrite,
  output logic [1:0]       resSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       ALUcontrol,
  output logic [1:0]       immSrc,
  output logic             regWrite,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_en, mem_en, reg_en, done_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_en     = 1'b0;
    mem_en    = 1'b0;
    reg_en    = 1'b0;
    done_en   = 1'b0;
    illegal   = 1'b0;
    adrSrc    = 1'b0;
    resSrc    = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        aluSrcB = SRCB_FOUR;
        resSrc  = RES_ALU;
        if (mem_ready) begin
          ir_en     = 1'b1;
          pc_update = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = ERROR;
        endcase
      end
      MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        resSrc  = RES_DATA;
        reg_en  = 1'b1;
        done_en = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adrSrc = 1'b1;
        mem_en = 1'b1;
        if (mem_ready) begin
          done_en = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_en  = 1'b1;
        done_en = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done_en = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      ERROR: begin
        illegal = 1'b1;
        state_d = ERROR;
      end
      default: state_d = FETCH;
    endcase
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_BR:   immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      default: immSrc = IMM_I;
    endcase
  end

  // Enables are gated by rst_n so they drop as soon as reset asserts,
  // without waiting for the asynchronous state reset to propagate a cycle.
  assign pcWrite    = rst_n & (pc_update | (branch & (zero ^ f3[0])));
  assign irWrite    = rst_n & ir_en;
  assign memWrite   = rst_n & mem_en;
  assign regWrite   = rst_n & reg_en;
  assign instr_done = rst_n & done_en;

  aluDeco u_alu_deco (
    .op5        (op[5]),
    .f7         (f7),
    .f3         (f3),
    .aluOp      (alu_op),
    .ALUcontrol (ALUcontrol)
  );

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instret <= '0;
    else if (instr_done) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    op;
  logic [2:0]    f3;
  logic          f7;
  logic          zero;
  logic          mem_ready;
  logic          pcWrite, adrSrc, irWrite, memWrite, regWrite, instr_done, illegal;
  logic [1:0]    resSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]    ALUcontrol;
  logic [CW-1:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .irWrite    (irWrite),
    .memWrite   (memWrite),
    .resSrc     (resSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .ALUcontrol (ALUcontrol),
    .immSrc     (immSrc),
    .regWrite   (regWrite),
    .instr_done (instr_done),
    .illegal    (illegal),
    .instret    (instret)
  );

  // Operation the ALU must perform in the third cycle of an instruction.
  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
    if (o == T_R || o == T_I) begin
      case (fn3)
        3'b000:  return (o == T_R && fn7) ? 3'b001 : 3'b000;
        3'b010:  return 3'b101;
        3'b110:  return 3'b011;
        3'b111:  return 3'b010;
        default: return 3'b000;
      endcase
    end
    if (o == T_BR) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == T_SW)  return 2'b01;
    if (o == T_BR)  return 2'b10;
    if (o == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Runs one instruction: nf fetch waits, nm memory waits.
  task automatic run_instr(input string name, input logic [6:0] op_i, input logic [2:0] f3_i,
                           input logic f7_i, input logic zero_i, input int nf, input int nm);
    bit is_mem, taken, done;
    int base, exp_lat, exp_pc, exp_reg, exp_mem, lat, c;
    int n_ir, n_pc, n_reg, n_mem, adr_bad;
    logic [1:0] res_seen, imm_seen, exp_res;
    logic [2:0] alu_seen, exp_alu;
    is_mem  = (op_i == T_LW) || (op_i == T_SW);
    taken   = (op_i == T_BR) && (zero_i ^ f3_i[0]);
    base    = (op_i == T_LW) ? 5 : (op_i == T_BR) ? 3 : 4;
    exp_lat = nf + base + (is_mem ? nm : 0);
    exp_pc  = 1 + ((op_i == T_JAL) ? 1 : 0) + (taken ? 1 : 0);
    exp_reg = (op_i == T_LW || op_i == T_R || op_i == T_I || op_i == T_JAL) ? 1 : 0;
    exp_mem = (op_i == T_SW) ? nm + 1 : 0;
    exp_res = (op_i == T_LW) ? 2'b01 : 2'b00;
    exp_alu = ref_alu(op_i, f3_i, f7_i);
    done = 0; c = 0; lat = 0;
    n_ir = 0; n_pc = 0; n_reg = 0; n_mem = 0; adr_bad = 0;
    res_seen = 2'b00; imm_seen = 2'bxx; alu_seen = 3'bxxx;
    while (!done && c < 64) begin
      @(negedge clk);
      op = op_i; f3 = f3_i; f7 = f7_i; zero = zero_i;
      if (c <= nf)                  mem_ready = (c == nf);
      else if (is_mem && c >= nf+3) mem_ready = (c >= nf + 3 + nm);
      else                          mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (irWrite === 1'b1) n_ir++;
      if (pcWrite === 1'b1) n_pc++;
      if (regWrite === 1'b1) begin n_reg++; res_seen = resSrc; end
      if (memWrite === 1'b1) begin n_mem++; if (adrSrc !== 1'b1) adr_bad++; end
      if (c == nf + 1) imm_seen = immSrc;
      if (c == nf + 2) alu_seen = ALUcontrol;
      if (instr_done === 1'b1) begin done = 1; lat = c + 1; end
      c++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: no instr_done within 64 cycles, expected %0d", name, exp_lat);
    end else if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (n_ir !== 1) begin n_fail++; $display("FAIL %s irWrite cycles: got %0d expected 1", name, n_ir); end
    n_checks++;
    if (n_pc !== exp_pc) begin n_fail++; $display("FAIL %s pcWrite cycles: got %0d expected %0d", name, n_pc, exp_pc); end
    n_checks++;
    if (n_reg !== exp_reg) begin n_fail++; $display("FAIL %s regWrite cycles: got %0d expected %0d", name, n_reg, exp_reg); end
    n_checks++;
    if (n_mem !== exp_mem) begin n_fail++; $display("FAIL %s memWrite cycles: got %0d expected %0d", name, n_mem, exp_mem); end
    n_checks++;
    if (adr_bad !== 0) begin n_fail++; $display("FAIL %s adrSrc during memWrite: %0d cycles not 1, expected 0", name, adr_bad); end
    n_checks++;
    if (exp_reg == 1 && res_seen !== exp_res) begin
      n_fail++; $display("FAIL %s resSrc at writeback: got %b expected %b", name, res_seen, exp_res);
    end
    n_checks++;
    if (imm_seen !== ref_imm(op_i)) begin
      n_fail++; $display("FAIL %s immSrc: got %b expected %b", name, imm_seen, ref_imm(op_i));
    end
    n_checks++;
    if (alu_seen !== exp_alu) begin
      n_fail++; $display("FAIL %s ALUcontrol: got %b expected %b", name, alu_seen, exp_alu);
    end
    @(posedge clk);
    #1;
    if (done) model_count++;
    n_checks++;
    if (instret !== CW'(model_count)) begin
      n_fail++; $display("FAIL %s instret: got %0d expected %0d", name, instret, CW'(model_count));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; op = T_LW; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
    #2;
    n_checks++;
    if ({pcWrite, irWrite, memWrite, regWrite, instr_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset enables: got %b expected 00000", {pcWrite, irWrite, memWrite, regWrite, instr_done});
    end
    n_checks++;
    if (instret !== '0) begin n_fail++; $display("FAIL reset instret: got %0d expected 0", instret); end
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset illegal: got %b expected 0", illegal); end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    model_count = 0;
  endtask

  task automatic test_lw;
    run_instr("lw", T_LW, 3'b010, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_sw;
    run_instr("sw_wait", T_SW, 3'b010, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_back_to_back;
    run_instr("sub", T_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("addi", T_I, 3'b000, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_branch;
    run_instr("beq_taken", T_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("bne_not_taken", T_BR, 3'b001, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_jal;
    run_instr("jal", T_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_error;
    @(negedge clk); op = 7'b1111111; mem_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({illegal, pcWrite, irWrite, memWrite, regWrite, instr_done} !== 6'b100000) begin
        n_fail++;
        $display("FAIL error_state cycle %0d: got illegal/enables %b expected 100000", i,
                 {illegal, pcWrite, irWrite, memWrite, regWrite, instr_done});
      end
    end
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL error_reset illegal: got %b expected 0", illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    model_count = 0;
    run_instr("after_error", T_I, 3'b110, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_abort;
    @(negedge clk); op = T_SW; f3 = 3'b010; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    #1;
    n_checks++;
    if (memWrite !== 1'b1) begin n_fail++; $display("FAIL abort pre memWrite: got %b expected 1", memWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({memWrite, regWrite, pcWrite, irWrite, instr_done} !== 5'b0) begin
      n_fail++; $display("FAIL abort enables: got %b expected 00000", {memWrite, regWrite, pcWrite, irWrite, instr_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_count = 0;
    run_instr("after_abort", T_R, 3'b111, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random;
    logic [6:0] ops [6];
    logic [2:0] alu_f3 [4];
    logic [6:0] o;
    logic [2:0] fn3;
    ops = '{T_LW, T_SW, T_R, T_I, T_BR, T_JAL};
    alu_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 5)];
      if (o == T_R || o == T_I)      fn3 = alu_f3[$urandom_range(0, 3)];
      else if (o == T_BR)            fn3 = 3'($urandom_range(0, 1));
      else                           fn3 = 3'b010;
      run_instr("random", o, fn3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sw;
    test_back_to_back;
    test_branch;
    test_jal;
    test_error;
    test_reset_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
